// File: rtl/relu_maxpool_cv.sv
// Post-convolution requantize, optional ReLU and 2x2/stride-2 max pooling over streamed columns.
// Build option: define RELU_MAXPOOL_RELU_EN to clamp requantized values at zero before pooling.
module relu_maxpool_cv #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned NUM_ROWS  = 24,
    parameter int unsigned NUM_COLS  = 24,
    parameter int unsigned SHIFT     = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clear,
    input  logic                                   valid_in,
    input  logic [IN_WIDTH*NUM_ROWS-1:0]           data_in,
    output logic                                   valid_out,
    output logic [OUT_WIDTH*(NUM_ROWS/2)-1:0]      data_out,
    output logic [$clog2(NUM_COLS/2):0]            out_col,
    output logic                                   frame_done,
    output logic                                   busy
);

    localparam int unsigned PAIRS     = NUM_ROWS / 2;
    localparam int unsigned OUT_COL_W = $clog2(NUM_COLS / 2) + 1;
    localparam int unsigned CNT_W     = $clog2(NUM_COLS + 1);
    localparam int unsigned LAST_EVEN = NUM_COLS - (NUM_COLS % 2);
    localparam bit          ODD_COLS  = (NUM_COLS % 2) == 1;

    localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
        IN_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {StIdle, StEven, StOdd, StDrain} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]                     col_cnt_q;
    logic [CNT_W:0]                       cnt_inc;
    logic                                 last_pair;
    logic signed [OUT_WIDTH-1:0]          col_buf_q [PAIRS];
    logic signed [OUT_WIDTH-1:0]          q_val [NUM_ROWS];
    logic signed [OUT_WIDTH-1:0]          v_val [PAIRS];
    logic [OUT_WIDTH*PAIRS-1:0]           data_out_d;
    logic [OUT_WIDTH*PAIRS-1:0]           data_out_q;
    logic                                 valid_out_q;
    logic                                 frame_done_q;
    logic [OUT_COL_W-1:0]                 out_col_q;

    // Requantize: arithmetic shift, saturate, then optional ReLU.
    always_comb begin
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            logic signed [IN_WIDTH-1:0] sh;
            sh = $signed(data_in[r*IN_WIDTH +: IN_WIDTH]) >>> SHIFT;
            if (sh > SAT_MAX) begin
                q_val[r] = SAT_MAX[OUT_WIDTH-1:0];
            end else if (sh < SAT_MIN) begin
                q_val[r] = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
                q_val[r] = sh[OUT_WIDTH-1:0];
            end
`ifdef RELU_MAXPOOL_RELU_EN
            if (q_val[r] < 0) begin
                q_val[r] = '0;
            end
`endif
        end
    end

    // Vertical pair max, then horizontal max against the buffered even column.
    always_comb begin
        data_out_d = '0;
        for (int unsigned j = 0; j < PAIRS; j++) begin
            v_val[j] = (q_val[2*j] > q_val[2*j+1]) ? q_val[2*j] : q_val[2*j+1];
            data_out_d[j*OUT_WIDTH +: OUT_WIDTH] =
                (col_buf_q[j] > v_val[j]) ? col_buf_q[j] : v_val[j];
        end
    end

    assign cnt_inc   = {1'b0, col_cnt_q} + (CNT_W+1)'(1);
    assign last_pair = cnt_inc >= (CNT_W+1)'(LAST_EVEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else if (valid_in) begin
            unique case (state_q)
                StIdle, StEven: state_d = StOdd;
                StOdd: begin
                    if (last_pair) begin
                        state_d = ODD_COLS ? StDrain : StIdle;
                    end else begin
                        state_d = StEven;
                    end
                end
                StDrain: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_col_q    <= '0;
            data_out_q   <= '0;
            for (int unsigned j = 0; j < PAIRS; j++) begin
                col_buf_q[j] <= '0;
            end
        end else begin
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (clear) begin
                col_cnt_q <= '0;
            end else if (valid_in) begin
                unique case (state_q)
                    StIdle: begin
                        col_buf_q <= v_val;
                        col_cnt_q <= CNT_W'(1);
                    end
                    StEven: begin
                        col_buf_q <= v_val;
                        col_cnt_q <= col_cnt_q + CNT_W'(1);
                    end
                    StOdd: begin
                        data_out_q   <= data_out_d;
                        valid_out_q  <= 1'b1;
                        out_col_q    <= OUT_COL_W'(col_cnt_q >> 1);
                        col_cnt_q    <= cnt_inc[CNT_W-1:0];
                        frame_done_q <= last_pair;
                    end
                    StDrain: begin
                        col_cnt_q <= col_cnt_q;
                    end
                endcase
            end
        end
    end

    assign valid_out  = valid_out_q;
    assign data_out   = data_out_q;
    assign out_col    = out_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool_cv.sv
// Directed bench for relu_maxpool_cv: an even 24-column instance and an odd 5-column instance.
module tb_relu_maxpool_cv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A: 4 rows, 24 columns, no shift
    logic         a_clear = 1'b0, a_valid = 1'b0;
    logic [127:0] a_din = '0;
    logic         a_vout, a_fd, a_busy;
    logic [31:0]  a_dout;
    logic [4:0]   a_col;

    // Instance B: 4 rows, 5 columns, shift 8
    logic         b_clear = 1'b0, b_valid = 1'b0;
    logic [127:0] b_din = '0;
    logic         b_vout, b_fd, b_busy;
    logic [31:0]  b_dout;
    logic [1:0]   b_col;

    relu_maxpool_cv #(
        .IN_WIDTH(32), .OUT_WIDTH(16), .NUM_ROWS(4), .NUM_COLS(24), .SHIFT(0)
    ) u_a (
        .clk(clk), .rst(rst), .clear(a_clear), .valid_in(a_valid), .data_in(a_din),
        .valid_out(a_vout), .data_out(a_dout), .out_col(a_col), .frame_done(a_fd),
        .busy(a_busy)
    );

    relu_maxpool_cv #(
        .IN_WIDTH(32), .OUT_WIDTH(16), .NUM_ROWS(4), .NUM_COLS(5), .SHIFT(8)
    ) u_b (
        .clk(clk), .rst(rst), .clear(b_clear), .valid_in(b_valid), .data_in(b_din),
        .valid_out(b_vout), .data_out(b_dout), .out_col(b_col), .frame_done(b_fd),
        .busy(b_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the beat consumed.
    task automatic beat_a(input logic [31:0] r0, r1, r2, r3, input logic clr);
        a_valid = 1'b1;
        a_clear = clr;
        a_din   = {r3, r2, r1, r0};
        @(negedge clk);
        a_valid = 1'b0;
        a_clear = 1'b0;
    endtask

    task automatic beat_b(input logic [31:0] r0, r1, r2, r3);
        b_valid = 1'b1;
        b_din   = {r3, r2, r1, r0};
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pulses;
        logic [31:0] exp;

        @(negedge clk);
        check("rst_a_vout", a_vout, 0);
        check("rst_a_dout", a_dout, 0);
        check("rst_a_col", a_col, 0);
        check("rst_a_fd", a_fd, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_b_vout", b_vout, 0);
        check("rst_b_dout", b_dout, 0);
        check("rst_b_busy", b_busy, 0);
        rst = 1'b0;

        // Basic pool
        beat_a(1, 5, -3, 2, 0);
        check("basic_first_vout", a_vout, 0);
        check("basic_first_busy", a_busy, 1);
        beat_a(4, 0, 7, -9, 0);
        check("basic_vout", a_vout, 1);
        check("basic_data", a_dout, 32'h0007_0005);
        check("basic_col", a_col, 0);
        check("basic_fd", a_fd, 0);
        idle(1);
        check("basic_pulse_drop", a_vout, 0);
        check("basic_hold", a_dout, 32'h0007_0005);

        // Clear alone returns to idle
        a_clear = 1'b1;
        idle(1);
        a_clear = 1'b0;
        check("clear_busy", a_busy, 0);

        // Full frame with random gaps
        pulses = 0;
        for (int c = 0; c < 24; c++) begin
            beat_a(c*10, c*10+1, c*10+2, c*10+3, 0);
            pulses += int'(a_vout);
            if (c % 2 == 1) begin
                exp = {16'(c*10+3), 16'(c*10+1)};
                check("frame_vout", a_vout, 1);
                check("frame_col", a_col, c/2);
                check("frame_fd", a_fd, (c == 23));
                check("frame_data", a_dout, exp);
            end else begin
                check("frame_even_vout", a_vout, 0);
            end
            if (c != 23) idle($urandom_range(0, 3));
        end
        check("frame_pulses", pulses, 12);
        idle(1);
        check("frame_busy_after", a_busy, 0);
        check("frame_fd_after", a_fd, 0);

        // Abort: clear with the second beat
        beat_a(100, 100, 100, 100, 0);
        beat_a(200, 200, 200, 200, 1);
        check("abort_vout", a_vout, 0);
        check("abort_busy", a_busy, 0);
        beat_a(2, 9, -1, -4, 0);
        check("abort_b1_vout", a_vout, 0);
        beat_a(3, 1, -5, 6, 0);
        check("abort_vout2", a_vout, 1);
        check("abort_col", a_col, 0);
        check("abort_data", a_dout, 32'h0006_0009);

        // Continue the frame, then async reset mid-frame
        beat_a(10, 20, 30, 40, 0);
        beat_a(50, 60, 70, 80, 0);
        check("pre_rst_col", a_col, 1);
        check("pre_rst_data", a_dout, 32'h0050_003C);
        beat_a(1, 1, 1, 1, 0);
        check("pre_rst_busy", a_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_vout", a_vout, 0);
        check("arst_dout", a_dout, 0);
        check("arst_col", a_col, 0);
        check("arst_fd", a_fd, 0);
        check("arst_busy", a_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        beat_a(7, 3, -2, -8, 0);
        check("post_rst_first", a_vout, 0);
        beat_a(1, 2, 9, 4, 0);
        check("post_rst_vout", a_vout, 1);
        check("post_rst_col", a_col, 0);
        check("post_rst_data", a_dout, 32'h0009_0007);

        // Saturation plus odd frame on instance B
        beat_b(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        check("sat_first_vout", b_vout, 0);
        beat_b(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        check("sat_pos_vout", b_vout, 1);
        check("sat_pos_data", b_dout, 32'h7FFF_7FFF);
        check("odd_col0", b_col, 0);
        check("odd_fd0", b_fd, 0);
        beat_b(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        beat_b(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        check("sat_neg_vout", b_vout, 1);
`ifdef RELU_MAXPOOL_RELU_EN
        check("sat_neg_data", b_dout, 32'h0000_0000);
`else
        check("sat_neg_data", b_dout, 32'h8000_8000);
`endif
        check("odd_col1", b_col, 1);
        check("odd_fd1", b_fd, 1);
        check("odd_drain_busy", b_busy, 1);
        beat_b(32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
        check("odd_drain_vout", b_vout, 0);
        check("odd_idle_busy", b_busy, 0);
        beat_b(32'h500, 32'h100, 32'h200, 32'h300);
        check("odd_next_first", b_vout, 0);
        beat_b(32'h000, 32'h400, 32'h600, 32'h100);
        check("odd_next_vout", b_vout, 1);
        check("odd_next_col", b_col, 0);
        check("odd_next_data", b_dout, 32'h0006_0005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/relu_maxpool_cv.md
Name: relu_maxpool_cv

Overview:
- Post-convolution stage. Consumes the column-parallel outputs of the convolution array, one image column per valid beat.
- Per beat: requantizes each value (arithmetic right shift, then saturate) and applies optional ReLU.
- Performs 2x2 max pooling with stride 2.
- Emits one pooled column for every two accepted input columns. Feeds the next layer's line buffer.

Parameters:
- IN_WIDTH, 32, signed width of each convolution result.
- OUT_WIDTH, 16, signed width of each pooled output.
- NUM_ROWS, 24, conv outputs per column (IMAGE_SIZE-KERNEL_SIZE+1). Must be at least 2.
- NUM_COLS, 24, conv columns per frame. Must be at least 2.
- SHIFT, 8, arithmetic right shift applied before saturation (fixed-point rescale).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous frame abort; returns block to IDLE
- valid_in  in  1  data_in carries one conv column this cycle
- data_in  in  IN_WIDTH x NUM_ROWS  signed conv column, index = output row
- valid_out  out  1  data_out holds a pooled column (1-cycle pulse)
- data_out  out  OUT_WIDTH x (NUM_ROWS/2)  signed pooled column
- out_col  out  $clog2(NUM_COLS/2)+1  index of the pooled column on data_out
- frame_done  out  1  1-cycle pulse: last pooled column of the frame emitted
- busy  out  1  high while not in IDLE

Behaviour:
- Reset (async): valid_out=0, data_out all 0, out_col=0, frame_done=0, busy=0, state=IDLE, column counter=0, column buffer all 0.
- Requantize, per element, combinational on input: q = data_in >>> SHIFT (sign-preserving), then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. With ReLU enabled, apply max(q,0) after saturation.
- Vertical pair: v[j] = max(q[2j], q[2j+1]), for j=0..NUM_ROWS/2-1. Odd NUM_ROWS: last row is ignored.
- State machine:
  - IDLE: on valid_in, store v into the column buffer, col_cnt<=1, go to ODD.
  - EVEN: on valid_in, store v, col_cnt++, go to ODD.
  - ODD: on valid_in, register data_out[j]=max(buf[j], v[j]) and pulse valid_out. Then:
    - out_col<=col_cnt>>1; col_cnt++.
    - If col_cnt+1 >= NUM_COLS - (NUM_COLS mod 2): pulse frame_done with the same valid_out, go to DRAIN if NUM_COLS is odd, else to IDLE.
    - Otherwise go to EVEN.
  - DRAIN (odd NUM_COLS only): accept and discard one beat on valid_in, then go to IDLE. No output.
  - No valid_in: stay in the current state. Gaps between beats are unlimited.
- Latency: valid_out is asserted the cycle after the odd-column beat. data_out holds its value until the next pooled column.
- Throughput: one column per cycle sustained. No backpressure; the upstream stage never stalls.
- clear: has priority over valid_in in the same cycle. Goes to IDLE, col_cnt=0, suppresses any pending valid_out/frame_done. data_out is retained.
- Reset mid-frame: identical to clear, but asynchronous, and data_out is zeroed.
- A new frame's valid_in in the cycle after frame_done is accepted as column 0.
- Equal values: max selects either (values are identical). Comparison is signed.

Optional Feature:
- Macro: RELU_MAXPOOL_RELU_EN.
- Defined: ReLU is applied before pooling; all data_out >= 0.
- Undefined: raw signed max pooling; negative outputs pass through.
- The pooling datapath and timing are identical in both builds.

Test Plan:
- Basic pool: NUM_ROWS=4, SHIFT=0, valid columns {1,5,-3,2} then {4,0,7,-9} -> one cycle after the second beat, valid_out=1, data_out={5,7}, out_col=0.
- Saturation/shift: SHIFT=8, input 0x7FFFFFFF on all rows -> data_out all 0x7FFF. Input 0x80000000 -> with RELU_MAXPOOL_RELU_EN all 0; without it all 0x8000.
- Full frame with gaps: 24 columns with random 0-3 idle cycles between beats -> exactly 12 valid_out pulses, out_col 0..11, frame_done coincident with out_col=11, busy low the cycle after.
- Odd frame: NUM_COLS=5 -> 2 outputs; the 5th beat is discarded; frame_done with the 2nd output; IDLE after the 5th beat.
- Abort: clear asserted alongside the 2nd beat -> no valid_out. The next two beats produce out_col=0 from those beats only.
- Async reset mid-frame after 3 beats -> all outputs 0 immediately. The following frame pools correctly from column 0.
